// File: rtl/ram_lsu_pkg.sv
// Shared types and lane helpers for the RAM load/store adapter.
package ram_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    // Reserved size falls through to word so the unchecked build treats it as a word access.
    function automatic logic [3:0] lane_enables(input size_e size, input logic [1:0] offset);
        case (size)
            SZ_BYTE: return 4'b0001 << offset;
            SZ_HALF: return 4'b0011 << {offset[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_replicate(input size_e size, input logic [31:0] data);
        case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] offset,
                                            input size_e size, input logic is_unsigned);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(word >> {offset, 3'b000});
        h = offset[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return is_unsigned ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: return is_unsigned ? {16'h0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/ram_lsu_extract.sv
// Combinational load-lane selection and sign/zero extension.
module ram_lsu_extract
    import ram_lsu_pkg::*;
(
    input  logic [31:0] readdata,
    input  logic [1:0]  offset,
    input  size_e       size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    assign result = extract(readdata, offset, size, is_unsigned);

endmodule

// File: rtl/ram_lsu_adapter.sv
// Core LSU request port to single-port synchronous RAM adapter.
// Optional macro RAM_LSU_MISALIGN_ERR_EN rejects misaligned and reserved-size requests.
module ram_lsu_adapter
    import ram_lsu_pkg::*;
#(
    parameter int RAM_AW = 10,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [RAM_AW-1:0] address,
    output logic [3:0]        byteenable,
    output logic              chipselect,
    output logic              write,
    output logic [31:0]       writedata,
    output logic              clken,
    input  logic [31:0]       readdata
);

    state_e              state, state_nxt;
    size_e               req_sz, size_q;
    logic                we_q, uns_q, err_q;
    logic [RAM_AW-1:0]   waddr_q;
    logic [1:0]          offset_q;
    logic [31:0]         wdata_q, rdata_q, ext_data;
    logic                accept, reject;

    assign req_sz = size_e'(req_size);
    assign accept = req_valid && req_ready;
    assign clken  = reset_n;
    assign rsp_rdata = rdata_q;

`ifdef RAM_LSU_MISALIGN_ERR_EN
    assign reject = (req_sz == SZ_RSVD) ||
                    (req_sz == SZ_HALF && req_addr[0]) ||
                    (req_sz == SZ_WORD && req_addr[1:0] != 2'b00);
`else
    assign reject = 1'b0;
`endif

    // Byte-address bits above the RAM window are dropped, so accesses wrap.
    if (ADDR_W > RAM_AW + 2) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^req_addr[ADDR_W-1:RAM_AW+2];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_err    = 1'b0;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        case (state)
            IDLE: begin
                req_ready = reset_n;
                if (req_valid && reset_n) state_nxt = reject ? RESP : ACCESS;
            end
            ACCESS: begin
                chipselect = 1'b1;
                write      = we_q;
                address    = waddr_q;
                byteenable = lane_enables(size_q, offset_q);
                writedata  = lane_replicate(size_q, wdata_q);
                state_nxt  = we_q ? RESP : CAPTURE;
            end
            CAPTURE: state_nxt = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= SZ_BYTE;
            waddr_q  <= '0;
            offset_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                uns_q    <= req_unsigned;
                err_q    <= reject;
                size_q   <= req_sz;
                waddr_q  <= req_addr[RAM_AW+1:2];
                offset_q <= req_addr[1:0];
                wdata_q  <= req_wdata;
                // Stores and rejects report zero data; loads keep the old value until capture.
                if (req_we || reject) rdata_q <= '0;
            end
            if (state == CAPTURE) rdata_q <= ext_data;
        end
    end

    ram_lsu_extract u_extract (
        .readdata    (readdata),
        .offset      (offset_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_data)
    );

endmodule
